// File: rtl/out_mem_reader_pkg.sv
// Shared types and derived constants for the output-memory drain path.
// Words are serialised MSB-first into byte_width-wide stream beats.
package out_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OUTPUT_MEMORY_WORD_SIZE = 32;
    localparam int OUTPUT_ADDRESS          = 3;
    localparam int BYTE_WIDTH              = 8;

    function automatic int bytes_per_word(input int word_size, input int byte_w);
        return word_size / byte_w;
    endfunction

    // Sized to hold bytes_per_word itself, so the counter cannot wrap inside a word.
    function automatic int count_width(input int bpw);
        return $clog2(bpw + 1);
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(OUTPUT_MEMORY_WORD_SIZE, BYTE_WIDTH);
    localparam int LAST_ADDR      = (2 ** OUTPUT_ADDRESS) - 1;

endpackage

// File: rtl/out_mem_reader_if.sv
// Byte stream from the output-memory reader to its consumer (valid/ready).
interface out_mem_reader_if #(
    parameter int byte_width = 8
);
    logic [byte_width-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_last;

    modport master (output tx_data, output tx_valid, output tx_last, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, input  tx_last, output tx_ready);
endinterface

// File: rtl/out_mem_reader_word_serializer.sv
// Parallel-load shift register that presents one word as a sequence of bytes,
// most-significant byte first, with a per-word byte counter.
module word_serializer
    import out_mem_pkg::*;
#(
    parameter int word_size  = 32,
    parameter int byte_width = 8,
    parameter int cnt_w      = count_width(bytes_per_word(word_size, byte_width))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [word_size-1:0]  word,
    output logic [byte_width-1:0] byte_out,
    output logic [cnt_w-1:0]      byte_count,
    output logic                  last_byte
);
    localparam int bpw = bytes_per_word(word_size, byte_width);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(bpw - 1);

    logic [word_size-1:0] shift_r;
    logic [cnt_w-1:0]     cnt_r;

    // Shift register and byte counter: load wins over shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r <= '0;
            cnt_r   <= '0;
        end else if (load) begin
            shift_r <= word;
            cnt_r   <= '0;
        end else if (shift) begin
            shift_r <= shift_r << byte_width;
            cnt_r   <= cnt_r + cnt_w'(1);
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
        end
    end

    assign byte_out   = shift_r[word_size-1 -: byte_width];
    assign byte_count = cnt_r;
    assign last_byte  = (cnt_r == cnt_last);

endmodule

// File: rtl/out_mem_reader.sv
// Drains the output memory in ascending address order and streams every word
// out as bytes; one start request drains all 2**output_address words.
module out_mem_reader
    import out_mem_pkg::*;
#(
    parameter int output_memory_word_size = 32,
    parameter int output_address          = 3,
    parameter int byte_width              = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [output_address-1:0]          mem_address,
    input  logic [output_memory_word_size-1:0] mem_word,
    out_mem_reader_if.master                   tx
);
    localparam int bpw   = bytes_per_word(output_memory_word_size, byte_width);
    localparam int cnt_w = count_width(bpw);
    localparam logic [output_address-1:0] last_addr   = '1;
    localparam logic [cnt_w-1:0]          cnt_penult  = cnt_w'(bpw - 2);

    state_t                    state_r;
    logic [output_address-1:0] addr_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      tx_valid_r;
    logic                      tx_last_r;

    logic                      load_s;
    logic                      handshake_s;
    logic [byte_width-1:0]     byte_s;
    logic [cnt_w-1:0]          byte_count_s;
    logic                      last_byte_s;

    assign load_s      = (state_r == FETCH);
    assign handshake_s = (state_r == SEND) && tx_valid_r && tx.tx_ready;

    word_serializer #(
        .word_size  (output_memory_word_size),
        .byte_width (byte_width),
        .cnt_w      (cnt_w)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .shift      (handshake_s),
        .word       (mem_word),
        .byte_out   (byte_s),
        .byte_count (byte_count_s),
        .last_byte  (last_byte_s)
    );

    // Control FSM: owns the address counter, status flags and stream qualifiers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_last_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        addr_r  <= '0;
                        busy_r  <= 1'b1;
                        state_r <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    tx_valid_r <= 1'b1;
                    tx_last_r  <= (addr_r == last_addr) && (bpw == 1);
                    state_r    <= SEND;
                end
                SEND: begin
                    if (handshake_s) begin
                        if (last_byte_s) begin
                            tx_valid_r <= 1'b0;
                            tx_last_r  <= 1'b0;
                            if (addr_r == last_addr) begin
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                state_r <= DONE;
                            end else begin
                                addr_r  <= addr_r + output_address'(1);
                                state_r <= FETCH;
                            end
                        end else begin
                            // Flag goes up with the beat that becomes the final byte.
                            tx_last_r <= (addr_r == last_addr) && (byte_count_s == cnt_penult);
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    tx_valid_r <= 1'b0;
                    tx_last_r  <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign mem_address = addr_r;
    assign tx.tx_data  = byte_s;
    assign tx.tx_valid = tx_valid_r;
    assign tx.tx_last  = tx_last_r;

endmodule

// File: tb/tb_out_mem_reader.sv
// Randomised self-checking bench for out_mem_reader against a byte-stream model.
module tb_out_mem_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  mem_address;
    logic [31:0] mem_word;
    logic [31:0] mem [8];

    int vectors     = 0;
    int miscompares = 0;

    out_mem_reader_if #(.byte_width(8)) tx_if ();

    out_mem_reader #(
        .output_memory_word_size (32),
        .output_address          (3),
        .byte_width              (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_word    (mem_word),
        .tx          (tx_if.master)
    );

    always #5 clk = ~clk;
    assign mem_word = mem[mem_address];

    // Monitor: records every accepted beat as {last, data} and protocol errors.
    logic [8:0] got_q [$];
    int   done_cnt = 0;
    int   stab_err = 0;
    int   drop_err = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pd = 8'h00;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (rst && tx_if.tx_valid && tx_if.tx_ready)
            got_q.push_back({tx_if.tx_last, tx_if.tx_data});
        if (rst && pv && !pr) begin
            if (!tx_if.tx_valid) drop_err <= drop_err + 1;
            else if (tx_if.tx_data !== pd || tx_if.tx_last !== pl) stab_err <= stab_err + 1;
        end
        pv <= rst & tx_if.tx_valid;
        pr <= tx_if.tx_ready;
        pd <= tx_if.tx_data;
        pl <= tx_if.tx_last;
    end

    // Reference model: MSB-first bytes of words 0..7, last flag on the final byte only.
    logic [8:0] exp_b [32];
    task automatic build_expected();
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 4; b++) begin
                exp_b[a*4 + b][7:0] = 8'((mem[a] >> (8 * (3 - b))) & 32'h0000_00FF);
                exp_b[a*4 + b][8]   = (a == 7) && (b == 3);
            end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 8; a++) mem[a] = $urandom;
    endtask

    // One drain run; done_k / first_k are cycle offsets from the start-sampling edge (-1 = not seen).
    task automatic run_drain(input int mode, input int extra_at, input bit start_on_done,
                             input int reset_at, output int done_k, output int first_k,
                             output bit rst_seen, output logic [4:0] snap);
        int base = got_q.size();
        int low_left = 0;
        bit extra_done = 1'b0;
        done_k = -1; first_k = -1; rst_seen = 1'b0; snap = 5'h1F;
        @(negedge clk);
        start = 1'b1;
        tx_if.tx_ready = (mode == 0);
        @(posedge clk);
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (tx_if.tx_valid && first_k < 0) first_k = k;
            if (done) begin
                done_k = k;
                if (start_on_done) start = 1'b1;
                break;
            end
            if (extra_at >= 0 && !extra_done && (got_q.size() - base) == extra_at) begin
                start = 1'b1;
                extra_done = 1'b1;
            end
            if (reset_at >= 0 && (got_q.size() - base) == reset_at && tx_if.tx_valid) begin
                rst = 1'b0;
                #1;
                snap = {tx_if.tx_valid, busy, mem_address};
                rst_seen = 1'b1;
                break;
            end
            if (mode != 0) begin
                if (low_left > 0) begin
                    tx_if.tx_ready = 1'b0;
                    low_left--;
                end else if ($urandom_range(0, 15) == 0) begin
                    tx_if.tx_ready = 1'b0;
                    low_left = 9;
                end else begin
                    tx_if.tx_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        if (start_on_done) begin
            @(negedge clk);
            start = 1'b0;
        end
        tx_if.tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; tx_if.tx_ready = 1'b0;
        for (int a = 0; a < 8; a++) mem[a] = 32'(a);
        repeat (3) @(negedge clk);
        vectors += 6;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        if (tx_if.tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", tx_if.tx_valid); end
        if (tx_if.tx_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b expected 0", tx_if.tx_last); end
        if (tx_if.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", tx_if.tx_data); end
        if (mem_address !== 3'd0) begin miscompares++; $display("FAIL reset_addr: got %0d expected 0", mem_address); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_drain();
        int done_k, first_k, base, dbase;
        bit rs;
        logic [4:0] sn;
        for (int a = 0; a < 8; a++) mem[a] = 32'(a);
        build_expected();
        base = got_q.size(); dbase = done_cnt;
        run_drain(0, -1, 1'b0, -1, done_k, first_k, rs, sn);
        vectors += 3;
        if (first_k !== 2) begin miscompares++; $display("FAIL basic_first_valid: got %0d expected 2", first_k); end
        if (done_k !== 41) begin miscompares++; $display("FAIL basic_done_latency: got %0d expected 41", done_k); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_done: got %b expected 0", busy); end
        repeat (5) @(negedge clk);
        vectors += 2;
        if (done_cnt - dbase !== 1) begin miscompares++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt - dbase); end
        if (got_q.size() - base !== 32) begin miscompares++; $display("FAIL basic_count: got %0d expected 32", got_q.size() - base); end
        for (int i = 0; i < 32; i++) begin
            vectors++;
            if (got_q[base + i] !== exp_b[i]) begin
                miscompares++; $display("FAIL basic_byte[%0d]: got %h expected %h", i, got_q[base + i], exp_b[i]);
            end
        end
    endtask

    task automatic test_byte_order();
        int done_k, first_k, base;
        bit rs;
        logic [4:0] sn;
        logic [7:0] head [4];
        head[0] = 8'hDE; head[1] = 8'hAD; head[2] = 8'hBE; head[3] = 8'hEF;
        fill_random();
        mem[0] = 32'hDEAD_BEEF;
        build_expected();
        base = got_q.size();
        run_drain(0, -1, 1'b0, -1, done_k, first_k, rs, sn);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got_q[base + i] !== {1'b0, head[i]}) begin
                miscompares++; $display("FAIL order_head[%0d]: got %h expected %h", i, got_q[base + i], head[i]);
            end
        end
        for (int i = 4; i < 32; i++) begin
            vectors++;
            if (got_q[base + i] !== exp_b[i]) begin
                miscompares++; $display("FAIL order_byte[%0d]: got %h expected %h", i, got_q[base + i], exp_b[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int done_k, first_k, base, dbase, sbase, xbase;
        bit rs;
        logic [4:0] sn;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            build_expected();
            base = got_q.size(); dbase = done_cnt; sbase = stab_err; xbase = drop_err;
            run_drain(1, -1, 1'b0, -1, done_k, first_k, rs, sn);
            repeat (3) @(negedge clk);
            vectors += 5;
            if (done_k < 0) begin miscompares++; $display("FAIL bp_timeout: got %0d expected done", done_k); end
            if (stab_err - sbase !== 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable beats expected 0", stab_err - sbase); end
            if (drop_err - xbase !== 0) begin miscompares++; $display("FAIL bp_drop: got %0d dropped beats expected 0", drop_err - xbase); end
            if (done_cnt - dbase !== 1) begin miscompares++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt - dbase); end
            if (got_q.size() - base !== 32) begin miscompares++; $display("FAIL bp_count: got %0d expected 32", got_q.size() - base); end
            for (int i = 0; i < 32; i++) begin
                vectors++;
                if (got_q[base + i] !== exp_b[i]) begin
                    miscompares++; $display("FAIL bp_byte[%0d]: got %h expected %h", i, got_q[base + i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int done_k, first_k, base, dbase;
        bit rs;
        logic [4:0] sn;
        fill_random();
        build_expected();
        base = got_q.size(); dbase = done_cnt;
        run_drain(0, 4, 1'b1, -1, done_k, first_k, rs, sn);
        repeat (50) @(negedge clk);
        vectors += 4;
        if (done_k !== 41) begin miscompares++; $display("FAIL swb_done_latency: got %0d expected 41", done_k); end
        if (done_cnt - dbase !== 1) begin miscompares++; $display("FAIL swb_done_pulses: got %0d expected 1", done_cnt - dbase); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL swb_busy_after: got %b expected 0", busy); end
        if (got_q.size() - base !== 32) begin miscompares++; $display("FAIL swb_count: got %0d expected 32", got_q.size() - base); end
        for (int i = 0; i < 32; i++) begin
            vectors++;
            if (got_q[base + i] !== exp_b[i]) begin
                miscompares++; $display("FAIL swb_byte[%0d]: got %h expected %h", i, got_q[base + i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int done_k, first_k, base, dbase;
        bit rs;
        logic [4:0] sn;
        fill_random();
        build_expected();
        base = got_q.size(); dbase = done_cnt;
        run_drain(0, -1, 1'b0, 9, done_k, first_k, rs, sn);
        vectors += 2;
        if (rs !== 1'b1) begin miscompares++; $display("FAIL rmr_reached: got %b expected 1", rs); end
        if (sn !== 5'b0) begin miscompares++; $display("FAIL rmr_snapshot: got %b expected 00000 (valid,busy,addr)", sn); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        vectors += 2;
        if (done_cnt - dbase !== 0) begin miscompares++; $display("FAIL rmr_no_done: got %0d expected 0", done_cnt - dbase); end
        if (got_q.size() - base !== 9) begin miscompares++; $display("FAIL rmr_partial: got %0d expected 9", got_q.size() - base); end
        base = got_q.size();
        run_drain(0, -1, 1'b0, -1, done_k, first_k, rs, sn);
        repeat (3) @(negedge clk);
        vectors++;
        if (done_k !== 41) begin miscompares++; $display("FAIL rmr_restart_latency: got %0d expected 41", done_k); end
        for (int i = 0; i < 32; i++) begin
            vectors++;
            if (got_q[base + i] !== exp_b[i]) begin
                miscompares++; $display("FAIL rmr_byte[%0d]: got %h expected %h", i, got_q[base + i], exp_b[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int done_k, first_k, base, lasts;
        bit rs;
        logic [4:0] sn;
        fill_random();
        build_expected();
        base = got_q.size();
        for (int r = 0; r < 2; r++) begin
            run_drain(0, -1, 1'b0, -1, done_k, first_k, rs, sn);
            vectors++;
            if (done_k !== 41) begin miscompares++; $display("FAIL b2b_done_latency[%0d]: got %0d expected 41", r, done_k); end
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (got_q.size() - base !== 64) begin miscompares++; $display("FAIL b2b_count: got %0d expected 64", got_q.size() - base); end
        for (int r = 0; r < 2; r++) begin
            lasts = 0;
            for (int i = 0; i < 32; i++) begin
                if (got_q[base + r*32 + i][8] === 1'b1) lasts++;
                vectors++;
                if (got_q[base + r*32 + i] !== exp_b[i]) begin
                    miscompares++; $display("FAIL b2b_byte[%0d][%0d]: got %h expected %h", r, i, got_q[base + r*32 + i], exp_b[i]);
                end
            end
            vectors++;
            if (lasts !== 1) begin miscompares++; $display("FAIL b2b_last_count[%0d]: got %0d expected 1", r, lasts); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_byte_order();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
